slc3_mem_arbiter: RTL and testbench

//  Shares the single on-chip SLC-3 program memory between two requesters: the CPU port (driven from ISDU Mem_OE/Mem_WE + MAR/MDR)
//  and a loader/debug port (program load, memory inspect). Serialises accesses, applies fixed read/write wait states, returns

---
 rtl/slc3_mem_pkg.sv | 23 ++
 rtl/slc3_mem_wait_timer.sv | 29 ++
 rtl/slc3_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_slc3_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and latency bounds for the SLC-3 program-memory arbiter.
// Imported by the arbiter top and its wait-state timer.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;

  function automatic logic lat_legal(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/slc3_mem_wait_timer.sv
// Loadable 3-bit down-counter that paces memory wait states.
// The zero flag marks the final cycle of an access.
module mem_wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [2:0] load_val,
  output logic       zero
);

  logic [2:0] count_r;

  // Load wins over decrement; the counter parks at zero instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 3'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != 3'd0)) begin
      count_r <= count_r - 3'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 3'd0);

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Shares the SLC-3 program memory between the CPU and loader ports with
// round-robin arbitration, fixed wait states and a one-cycle ack per access.
module slc3_mem_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_ldr
);

  if (!lat_legal(READ_LAT)) begin : g_bad_read_lat
    $error("slc3_mem_arbiter: READ_LAT must be in 1..7");
  end
  if (!lat_legal(WRITE_LAT)) begin : g_bad_write_lat
    $error("slc3_mem_arbiter: WRITE_LAT must be in 1..7");
  end

  localparam logic [2:0] RD_LOAD = 3'(READ_LAT - 1);
  localparam logic [2:0] WR_LOAD = 3'(WRITE_LAT - 1);

  arb_state_t        state_r;
  owner_t            owner_r;
  logic              we_r;
  logic              cpu_ack_r;
  logic              ldr_ack_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic [DATA_W-1:0] ldr_rdata_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_rden_r;
  logic              mem_wren_r;
  logic              busy_r;
  logic              grant_ldr_r;

  owner_t            pick_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              start_s;
  logic              timer_en_s;
  logic              timer_zero_s;
  logic [2:0]        timer_load_val_s;

  // Round-robin pick: on a tie the port that did not own the last access wins
  always_comb begin
    pick_s      = OWN_CPU;
    sel_we_s    = cpu_we;
    sel_addr_s  = cpu_addr;
    sel_wdata_s = cpu_wdata;
    if (cpu_req && ldr_req) begin
      if (owner_r == OWN_CPU) begin
        pick_s = OWN_LDR;
      end else begin
        pick_s = OWN_CPU;
      end
    end else if (ldr_req) begin
      pick_s = OWN_LDR;
    end else begin
      pick_s = OWN_CPU;
    end
    if (pick_s == OWN_LDR) begin
      sel_we_s    = ldr_we;
      sel_addr_s  = ldr_addr;
      sel_wdata_s = ldr_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
  end

  assign start_s          = (state_r == ARB_IDLE) && (cpu_req || ldr_req);
  assign timer_en_s       = (state_r == ARB_ACCESS);
  assign timer_load_val_s = sel_we_s ? WR_LOAD : RD_LOAD;

  mem_wait_timer u_timer (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (start_s),
    .en       (timer_en_s),
    .load_val (timer_load_val_s),
    .zero     (timer_zero_s)
  );

  // Access sequencer; every output is driven from a register here
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ARB_IDLE;
      owner_r     <= OWN_LDR;
      we_r        <= 1'b0;
      cpu_ack_r   <= 1'b0;
      ldr_ack_r   <= 1'b0;
      cpu_rdata_r <= {DATA_W{1'b0}};
      ldr_rdata_r <= {DATA_W{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_rden_r  <= 1'b0;
      mem_wren_r  <= 1'b0;
      busy_r      <= 1'b0;
      grant_ldr_r <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (start_s) begin
            state_r     <= ARB_ACCESS;
            owner_r     <= pick_s;
            grant_ldr_r <= (pick_s == OWN_LDR);
            we_r        <= sel_we_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            mem_rden_r  <= ~sel_we_s;
            mem_wren_r  <= sel_we_s;
            busy_r      <= 1'b1;
          end
        end
        ARB_ACCESS: begin
          // The write strobe lasts one cycle regardless of WRITE_LAT
          mem_wren_r <= 1'b0;
          if (timer_zero_s) begin
            state_r    <= ARB_DONE;
            mem_rden_r <= 1'b0;
            if (owner_r == OWN_LDR) begin
              ldr_ack_r <= 1'b1;
              if (!we_r) begin
                ldr_rdata_r <= mem_rdata;
              end
            end else begin
              cpu_ack_r <= 1'b1;
              if (!we_r) begin
                cpu_rdata_r <= mem_rdata;
              end
            end
          end
        end
        ARB_DONE: begin
          state_r   <= ARB_IDLE;
          cpu_ack_r <= 1'b0;
          ldr_ack_r <= 1'b0;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r    <= ARB_IDLE;
          cpu_ack_r  <= 1'b0;
          ldr_ack_r  <= 1'b0;
          mem_rden_r <= 1'b0;
          mem_wren_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_r;
  assign ldr_ack   = ldr_ack_r;
  assign cpu_rdata = cpu_rdata_r;
  assign ldr_rdata = ldr_rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_rden  = mem_rden_r;
  assign mem_wren  = mem_wren_r;
  assign busy      = busy_r;
  assign grant_ldr = grant_ldr_r;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed, table-driven bench for slc3_mem_arbiter with a latency-aware memory model.
module tb_slc3_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int WL = 1;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, ldr_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, ldr_wdata = '0;
  logic          cpu_ack, ldr_ack, mem_rden, mem_wren, busy, grant_ldr;
  logic [DW-1:0] cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  slc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .busy(busy), .grant_ldr(grant_ldr)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] pat(input int a);
    return 16'hC000 + 16'(a);
  endfunction

  // Memory model: data is only valid once rden has been held READ_LAT cycles
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            rd_cnt = 0;
  always @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
    end else if (mem_wren) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_cnt <= mem_rden ? rd_cnt + 1 : 0;
  end
  assign mem_rdata = (mem_rden && (rd_cnt + 1 >= RL)) ? mem[mem_addr] : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  // One access from an idle arbiter; checks latency, strobes, data and isolation
  task automatic run_txn(input vec_t v, input int idx);
    int ack_c = -1, rden_n = 0, wren_n = 0, other = 0;
    logic [DW-1:0] rd = '0;
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge Clk);
    if (v.port) begin
      ldr_req = 1'b1; ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int c = 0; c < 20 && ack_c < 0; c++) begin
      @(negedge Clk);
      if (mem_rden) rden_n++;
      if (mem_wren) wren_n++;
      if (v.port ? cpu_ack : ldr_ack) other++;
      if (c == 0) begin
        check({t, " grant"}, 32'(grant_ldr), 32'(v.port));
        check({t, " mem_addr"}, 32'(mem_addr), 32'(v.addr));
        if (v.we) check({t, " mem_wdata"}, 32'(mem_wdata), 32'(v.wdata));
      end
      if (v.port ? ldr_ack : cpu_ack) begin
        ack_c = c;
        rd = v.port ? ldr_rdata : cpu_rdata;
      end
    end
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    check({t, " ack_cycle"}, 32'(ack_c), 32'(v.we ? WL : RL));
    if (!v.we) check({t, " rdata"}, 32'(rd), 32'(v.exp_rd));
    check({t, " rden_cycles"}, 32'(rden_n), 32'(v.we ? 0 : RL));
    check({t, " wren_cycles"}, 32'(wren_n), 32'(v.we ? 1 : 0));
    check({t, " other_ack"}, 32'(other), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [8];
    int n, cn, ln, ack_c, ldr_c, cpu_c, ack_cnt;
    logic [3:0] order;
    int ack_at [4];

    vecs[0] = '{1'b0, 1'b1, 10'h005, 16'h1234, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 10'h005, 16'h0000, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 10'h00A, 16'hBEEF, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 10'h00A, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b0, 10'h005, 16'h0000, 16'h1234};
    vecs[5] = '{1'b1, 1'b1, 10'h3FF, 16'hA5A5, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 10'h3FF, 16'h0000, 16'hA5A5};
    vecs[7] = '{1'b1, 1'b0, 10'h100, 16'h0000, 16'hC100};

    // Reset values
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst acks", 32'({cpu_ack, ldr_ack}), 32'd0);
    check("rst strobes", 32'({mem_rden, mem_wren}), 32'd0);
    check("rst grant", 32'(grant_ldr), 32'd0);
    check("rst cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst ldr_rdata", 32'(ldr_rdata), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_wdata", 32'(mem_wdata), 32'd0);

    // Both requesting after reset: CPU first, then strict alternation
    cpu_we = 1'b0; cpu_addr = 10'h001; ldr_we = 1'b0; ldr_addr = 10'h002;
    cpu_req = 1'b1; ldr_req = 1'b1;
    n = 0; cn = 0; ln = 0; order = '0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge Clk);
      if (cpu_ack) begin
        order[n] = 1'b0; n++; cn++;
        check("rr cpu_rdata", 32'(cpu_rdata), 32'(pat(1)));
        if (cn == 2) cpu_req = 1'b0;
      end
      if (ldr_ack) begin
        order[n] = 1'b1; n++; ln++;
        check("rr ldr_rdata", 32'(ldr_rdata), 32'(pat(2)));
        if (ln == 2) ldr_req = 1'b0;
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    check("rr ack_count", 32'(n), 32'd4);
    check("rr order", 32'(order), 32'(4'b1010));

    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // Back-to-back CPU reads with req held; address advances on each ack
    @(negedge Clk);
    cpu_we = 1'b0; cpu_addr = 10'h000; cpu_req = 1'b1;
    n = 0; ln = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge Clk);
      if (ldr_ack) ln++;
      if (cpu_ack) begin
        ack_at[n] = c;
        check($sformatf("b2b rdata%0d", n), 32'(cpu_rdata), 32'(pat(n)));
        n++;
        if (n < 4) cpu_addr = AW'(n);
        else cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    check("b2b ack_count", 32'(n), 32'd4);
    for (int k = 0; k < n; k++) check($sformatf("b2b ack_at%0d", k), 32'(ack_at[k]), 32'(2 + 4 * k));
    check("b2b ldr_ack", 32'(ln), 32'd0);

    // Loader request arriving mid CPU access waits for the first idle edge
    @(negedge Clk);
    cpu_we = 1'b0; cpu_addr = 10'h00A; cpu_req = 1'b1;
    cpu_c = -1; ldr_c = -1;
    for (int c = 0; c < 20 && ldr_c < 0; c++) begin
      @(negedge Clk);
      if (c <= 2) begin
        check($sformatf("late c%0d mem_addr", c), 32'(mem_addr), 32'h00A);
        check($sformatf("late c%0d wren", c), 32'(mem_wren), 32'd0);
        check($sformatf("late c%0d grant", c), 32'(grant_ldr), 32'd0);
      end
      if (c == 4) begin
        check("late ldr grant", 32'(grant_ldr), 32'd1);
        check("late ldr wren", 32'(mem_wren), 32'd1);
        check("late ldr addr", 32'(mem_addr), 32'h123);
      end
      if (cpu_ack) begin cpu_c = c; cpu_req = 1'b0; end
      if (ldr_ack) begin ldr_c = c; ldr_req = 1'b0; end
      if (c == 0) begin
        ldr_we = 1'b1; ldr_addr = 10'h123; ldr_wdata = 16'h7E57; ldr_req = 1'b1;
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    check("late cpu_ack_at", 32'(cpu_c), 32'd2);
    check("late cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    check("late ldr_ack_at", 32'(ldr_c), 32'd5);
    run_txn('{1'b0, 1'b0, 10'h123, 16'h0000, 16'h7E57}, 8);

    // Request dropped before ack still completes
    @(negedge Clk);
    cpu_we = 1'b0; cpu_addr = 10'h3FF; cpu_req = 1'b1;
    ack_c = -1;
    for (int c = 0; c < 20 && ack_c < 0; c++) begin
      @(negedge Clk);
      cpu_req = 1'b0;
      if (cpu_ack) ack_c = c;
    end
    check("drop ack_at", 32'(ack_c), 32'd2);
    check("drop rdata", 32'(cpu_rdata), 32'hA5A5);

    // Reset in the middle of a CPU read drops the access
    @(negedge Clk);
    cpu_we = 1'b0; cpu_addr = 10'h001; cpu_req = 1'b1;
    @(negedge Clk);
    check("mid rden before rst", 32'(mem_rden), 32'd1);
    Reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst rden", 32'(mem_rden), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    ack_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (cpu_ack) ack_cnt++;
    end
    check("mid rst no ack", 32'(ack_cnt), 32'd0);
    check("mid rst busy after", 32'(busy), 32'd0);
    check("mid rst cpu_rdata", 32'(cpu_rdata), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
